sd_init_sequencer: RTL and testbench

SD_INIT_SEQUENCER -- requirements
Module: sd_init_sequencer

---
 rtl/sd_init_sequencer.sv | 259 +++++++++++++++++++++++++
 tb/tb_sd_init_sequencer.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_init_sequencer.sv
// SD card initialization sequencer: CMD0, CMD8, ACMD41 polling, CMD2, CMD3.
// Drives an external command writer and reads responses back word by word.
module sd_init_sequencer #(
  parameter int          RETRY_MAX  = 2047,
  parameter logic [31:0] ACMD41_ARG = 32'h40FF8000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        fail,
  output logic [2:0]  err_code,
  output logic [15:0] rca,
  output logic [31:0] ocr,
  output logic        high_cap,
  output logic        v1_card,
  output logic [37:0] cmd_out,
  output logic        exp_r2,
  output logic        send_cmd_req,
  input  logic        cmd_busy,
  input  logic        resp_done,
  input  logic        err_index,
  input  logic        err_crc,
  input  logic        err_end_bit,
  input  logic        err_timeout,
  output logic [1:0]  resp_addr,
  output logic        resp_change,
  input  logic [31:0] resp_word
);

  localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [RW-1:0] RMAX = RW'(RETRY_MAX);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_FETCH  = 3'd3;
  localparam logic [2:0] S_LATCH  = 3'd4;
  localparam logic [2:0] S_DECIDE = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_FAIL   = 3'd7;

  localparam logic [2:0] T_CMD0  = 3'd0;
  localparam logic [2:0] T_CMD8  = 3'd1;
  localparam logic [2:0] T_CMD55 = 3'd2;
  localparam logic [2:0] T_CMD41 = 3'd3;
  localparam logic [2:0] T_CMD2  = 3'd4;
  localparam logic [2:0] T_CMD3  = 3'd5;

  localparam logic [2:0] E_ECHO  = 3'd1;
  localparam logic [2:0] E_RESP  = 3'd2;
  localparam logic [2:0] E_RETRY = 3'd3;
  localparam logic [2:0] E_TMO   = 3'd4;

  logic [2:0]    state;
  logic [2:0]    step;
  logic [RW-1:0] retry;
  logic [31:0]   resp_q;
  logic          f_idx, f_crc, f_end, f_to;

  logic       d_go, d_fin, d_set_v1, d_ld_ocr, d_inc, d_ld_rca;
  logic [2:0] d_next, d_code;
  logic       e_any;

  // Command word for a step; a v1 card must not advertise HCS.
  function automatic logic [37:0] cmd_of(input logic [2:0] s,
                                         input logic v1);
    logic [31:0] a41;
    a41 = v1 ? (ACMD41_ARG & 32'hBFFF_FFFF) : ACMD41_ARG;
    unique case (s)
      T_CMD8:  cmd_of = {6'd8, 32'h0000_01AA};
      T_CMD55: cmd_of = {6'd55, 32'd0};
      T_CMD41: cmd_of = {6'd41, a41};
      T_CMD2:  cmd_of = {6'd2, 32'd0};
      T_CMD3:  cmd_of = {6'd3, 32'd0};
      default: cmd_of = {6'd0, 32'd0};
    endcase
  endfunction

  assign resp_change = (state == S_FETCH);
  assign resp_addr   = (state == S_FETCH || state == S_LATCH) ? 2'd1 : 2'd0;

  // Classify the latched response of the current step; timeout wins.
  always_comb begin
    d_go     = 1'b0;
    d_fin    = 1'b0;
    d_next   = T_CMD0;
    d_code   = 3'd0;
    d_set_v1 = 1'b0;
    d_ld_ocr = 1'b0;
    d_inc    = 1'b0;
    d_ld_rca = 1'b0;
    e_any    = f_idx | f_crc | f_end;
    unique case (step)
      T_CMD0: begin
        d_go   = 1'b1;
        d_next = T_CMD8;
      end
      T_CMD8: begin
        if (f_to) begin
          d_set_v1 = 1'b1;
          d_go     = 1'b1;
          d_next   = T_CMD55;
        end else if (e_any) begin
          d_code = E_RESP;
        end else if (resp_q[11:0] != 12'h1AA) begin
          d_code = E_ECHO;
        end else begin
          d_go   = 1'b1;
          d_next = T_CMD55;
        end
      end
      T_CMD55: begin
        if (f_to)
          d_code = E_TMO;
        else if (e_any)
          d_code = E_RESP;
        else begin
          d_go   = 1'b1;
          d_next = T_CMD41;
        end
      end
      T_CMD41: begin
        if (f_to)
          d_code = E_TMO;
        else if (f_end)
          d_code = E_RESP;
        else begin
          d_ld_ocr = 1'b1;
          if (resp_q[31]) begin
            d_go   = 1'b1;
            d_next = T_CMD2;
          end else if (retry == RMAX) begin
            d_code = E_RETRY;
          end else begin
            d_inc  = 1'b1;
            d_go   = 1'b1;
            d_next = T_CMD55;
          end
        end
      end
      T_CMD2: begin
        if (f_to)
          d_code = E_TMO;
        else if (f_crc | f_end)
          d_code = E_RESP;
        else begin
          d_go   = 1'b1;
          d_next = T_CMD3;
        end
      end
      T_CMD3: begin
        if (f_to)
          d_code = E_TMO;
        else if (e_any)
          d_code = E_RESP;
        else begin
          d_ld_rca = 1'b1;
          d_fin    = 1'b1;
        end
      end
      default: d_code = E_RESP;
    endcase
  end

  // Main sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= S_IDLE;
      step         <= T_CMD0;
      retry        <= '0;
      resp_q       <= 32'd0;
      f_idx        <= 1'b0;
      f_crc        <= 1'b0;
      f_end        <= 1'b0;
      f_to         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fail         <= 1'b0;
      err_code     <= 3'd0;
      rca          <= 16'd0;
      ocr          <= 32'd0;
      high_cap     <= 1'b0;
      v1_card      <= 1'b0;
      cmd_out      <= 38'd0;
      exp_r2       <= 1'b0;
      send_cmd_req <= 1'b0;
    end else begin
      send_cmd_req <= 1'b0;
      done         <= 1'b0;
      fail         <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_ISSUE;
            busy     <= 1'b1;
            step     <= T_CMD0;
            cmd_out  <= cmd_of(T_CMD0, 1'b0);
            exp_r2   <= 1'b0;
            err_code <= 3'd0;
            rca      <= 16'd0;
            ocr      <= 32'd0;
            v1_card  <= 1'b0;
            retry    <= '0;
          end
        end
        S_ISSUE: begin
          if (!cmd_busy) begin
            send_cmd_req <= 1'b1;
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (resp_done) begin
            f_idx <= err_index;
            f_crc <= err_crc;
            f_end <= err_end_bit;
            f_to  <= err_timeout;
            state <= S_FETCH;
          end
        end
        S_FETCH: state <= S_LATCH;
        S_LATCH: begin
          resp_q <= resp_word;
          state  <= S_DECIDE;
        end
        S_DECIDE: begin
          if (d_set_v1) v1_card <= 1'b1;
          if (d_ld_ocr) ocr <= resp_q;
          if (d_inc) retry <= retry + 1'b1;
          if (d_ld_rca) rca <= resp_q[31:16];
          if (d_go) begin
            step    <= d_next;
            cmd_out <= cmd_of(d_next, v1_card);
            exp_r2  <= (d_next == T_CMD2);
            state   <= S_ISSUE;
          end else if (d_fin) begin
            state    <= S_DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
            exp_r2   <= 1'b0;
            high_cap <= ocr[30];
          end else begin
            state    <= S_FAIL;
            fail     <= 1'b1;
            busy     <= 1'b0;
            exp_r2   <= 1'b0;
            err_code <= d_code;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_FAIL:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Directed bench for sd_init_sequencer with a scripted card responder.
// Built with RETRY_MAX=2 so retry exhaustion is reachable quickly.
module tb_sd_init_sequencer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, fail;
  logic [2:0]  err_code;
  logic [15:0] rca;
  logic [31:0] ocr;
  logic        high_cap, v1_card;
  logic [37:0] cmd_out;
  logic        exp_r2, send_cmd_req;
  logic        cmd_busy = 1'b0;
  logic        resp_done = 1'b0;
  logic        err_index = 1'b0;
  logic        err_crc = 1'b0;
  logic        err_end_bit = 1'b0;
  logic        err_timeout = 1'b0;
  logic [1:0]  resp_addr;
  logic        resp_change;
  logic [31:0] resp_word = 32'd0;

  sd_init_sequencer #(.RETRY_MAX(2), .ACMD41_ARG(32'h40FF8000)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .busy(busy), .done(done), .fail(fail),
    .err_code(err_code), .rca(rca), .ocr(ocr),
    .high_cap(high_cap), .v1_card(v1_card),
    .cmd_out(cmd_out), .exp_r2(exp_r2),
    .send_cmd_req(send_cmd_req), .cmd_busy(cmd_busy),
    .resp_done(resp_done), .err_index(err_index),
    .err_crc(err_crc), .err_end_bit(err_end_bit),
    .err_timeout(err_timeout), .resp_addr(resp_addr),
    .resp_change(resp_change), .resp_word(resp_word)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  flags;
    logic [31:0] word;
  } rsp_t;

  localparam logic [3:0] F_OK  = 4'b0000;
  localparam logic [3:0] F_TO  = 4'b0001;
  localparam logic [3:0] F_END = 4'b0010;
  localparam logic [3:0] F_CRC = 4'b0100;
  localparam logic [3:0] F_IDX = 4'b1000;

  localparam logic [38:0] C0   = {1'b0, 6'd0, 32'd0};
  localparam logic [38:0] C8   = {1'b0, 6'd8, 32'h1AA};
  localparam logic [38:0] C55  = {1'b0, 6'd55, 32'd0};
  localparam logic [38:0] C41  = {1'b0, 6'd41, 32'h40FF8000};
  localparam logic [38:0] C41V = {1'b0, 6'd41, 32'h00FF8000};
  localparam logic [38:0] C2   = {1'b1, 6'd2, 32'd0};
  localparam logic [38:0] C3   = {1'b0, 6'd3, 32'd0};

  rsp_t        rq[$];
  logic [38:0] cmd_log[$];
  int          done_cnt = 0;
  int          fail_cnt = 0;
  int          nvec = 0;
  int          nmis = 0;
  bit          pend = 0;
  int          dly = 0;

  // Card model: logs each request, answers from the script after a delay.
  always @(negedge clk) begin
    rsp_t r;
    resp_done   = 1'b0;
    err_index   = 1'b0;
    err_crc     = 1'b0;
    err_end_bit = 1'b0;
    err_timeout = 1'b0;
    if (done) done_cnt++;
    if (fail) fail_cnt++;
    if (!resetn) begin
      pend = 0;
      dly  = 0;
    end else if (send_cmd_req) begin
      cmd_log.push_back({exp_r2, cmd_out});
      pend = 1;
      dly  = 2;
    end else if (pend) begin
      if (dly > 0) dly--;
      else begin
        pend = 0;
        if (rq.size() > 0) begin
          r = rq.pop_front();
          {err_index, err_crc, err_end_bit, err_timeout} = r.flags;
          resp_word = r.word;
          resp_done = 1'b1;
        end
      end
    end
  end

  task automatic push(input logic [3:0] f, input logic [31:0] w);
    rsp_t r;
    r.flags = f;
    r.word  = w;
    rq.push_back(r);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_end(input string nm, input int budget);
    int n;
    int d0;
    int f0;
    n  = 0;
    d0 = done_cnt;
    f0 = fail_cnt;
    while (done_cnt == d0 && fail_cnt == f0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    nvec++;
    if (n >= budget) begin
      nmis++;
      $display("FAIL %s: no done/fail after %0d cycles", nm, budget);
    end
  endtask

  task automatic wait_log(input string nm, input int sz);
    int n;
    n = 0;
    while (cmd_log.size() < sz && n < 500) begin
      @(negedge clk);
      n++;
    end
    nvec++;
    if (cmd_log.size() < sz) begin
      nmis++;
      $display("FAIL %s: log size %0d, need %0d", nm, cmd_log.size(), sz);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle(3);
    nvec++;
    if ({busy, done, fail, send_cmd_req, resp_change, exp_r2,
         v1_card, high_cap} !== 8'h00) begin
      nmis++;
      $display("FAIL reset_flags: got %b, need 00000000",
               {busy, done, fail, send_cmd_req, resp_change, exp_r2,
                v1_card, high_cap});
    end
    nvec++;
    if ({err_code, rca, ocr, cmd_out, resp_addr} !== 91'd0) begin
      nmis++;
      $display("FAIL reset_regs: err=%0d rca=%h ocr=%h cmd=%h addr=%0d",
               err_code, rca, ocr, cmd_out, resp_addr);
    end
    resetn = 1'b1;
    idle(2);
  endtask

  task automatic test_happy();
    logic [38:0] e[10];
    int d0;
    int f0;
    e = '{C0, C8, C55, C41, C55, C41, C55, C41, C2, C3};
    cmd_log.delete();
    d0 = done_cnt;
    f0 = fail_cnt;
    push(F_TO, 32'd0);
    push(F_OK, 32'h0000_01AA);
    push(F_OK, 32'd0);
    push(F_OK, 32'h00FF_8000);
    push(F_OK, 32'd0);
    push(F_CRC | F_IDX, 32'h00FF_8000);
    push(F_OK, 32'd0);
    push(F_OK, 32'hC0FF_8000);
    push(F_IDX, 32'd0);
    push(F_OK, 32'h1234_0500);
    pulse_start();
    nvec++;
    if (busy !== 1'b1) begin
      nmis++;
      $display("FAIL happy_busy: got %b, need 1", busy);
    end
    wait_end("happy_end", 400);
    nvec++;
    if (done_cnt - d0 != 1 || fail_cnt != f0 || busy !== 1'b0) begin
      nmis++;
      $display("FAIL happy_pulse: done %0d fail %0d busy %b, need 1 0 0",
               done_cnt - d0, fail_cnt - f0, busy);
    end
    nvec++;
    if (rca !== 16'h1234 || high_cap !== 1'b1 || ocr !== 32'hC0FF8000 ||
        v1_card !== 1'b0 || err_code !== 3'd0) begin
      nmis++;
      $display("FAIL happy_regs: rca=%h hc=%b ocr=%h v1=%b err=%0d",
               rca, high_cap, ocr, v1_card, err_code);
    end
    nvec++;
    if (cmd_log.size() != 10) begin
      nmis++;
      $display("FAIL happy_count: got %0d, need 10", cmd_log.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        nvec++;
        if (cmd_log[i] !== e[i]) begin
          nmis++;
          $display("FAIL happy_cmd%0d: got %h, need %h", i, cmd_log[i], e[i]);
        end
      end
    end
    idle(3);
  endtask

  task automatic test_v1();
    logic [38:0] e[6];
    e = '{C0, C8, C55, C41V, C2, C3};
    cmd_log.delete();
    push(F_OK, 32'd0);
    push(F_TO, 32'd0);
    push(F_OK, 32'd0);
    push(F_OK, 32'h80FF_8000);
    push(F_OK, 32'd0);
    push(F_OK, 32'hABCD_0000);
    pulse_start();
    wait_end("v1_end", 300);
    nvec++;
    if (v1_card !== 1'b1 || high_cap !== 1'b0 || rca !== 16'hABCD ||
        ocr !== 32'h80FF8000 || done !== 1'b0) begin
      nmis++;
      $display("FAIL v1_regs: v1=%b hc=%b rca=%h ocr=%h",
               v1_card, high_cap, rca, ocr);
    end
    nvec++;
    if (cmd_log.size() != 6) begin
      nmis++;
      $display("FAIL v1_count: got %0d, need 6", cmd_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        nvec++;
        if (cmd_log[i] !== e[i]) begin
          nmis++;
          $display("FAIL v1_cmd%0d: got %h, need %h", i, cmd_log[i], e[i]);
        end
      end
    end
    idle(3);
  endtask

  task automatic test_echo();
    int f0;
    cmd_log.delete();
    f0 = fail_cnt;
    push(F_OK, 32'd0);
    push(F_OK, 32'h0000_00AA);
    pulse_start();
    wait_end("echo_end", 200);
    nvec++;
    if (fail_cnt - f0 != 1 || err_code !== 3'd1 || busy !== 1'b0) begin
      nmis++;
      $display("FAIL echo_fail: fails %0d err %0d busy %b, need 1 1 0",
               fail_cnt - f0, err_code, busy);
    end
    idle(10);
    nvec++;
    if (cmd_log.size() != 2 || err_code !== 3'd1) begin
      nmis++;
      $display("FAIL echo_quiet: log %0d err %0d, need 2 1",
               cmd_log.size(), err_code);
    end
  endtask

  task automatic test_retry();
    int n41;
    cmd_log.delete();
    push(F_OK, 32'd0);
    push(F_OK, 32'h0000_01AA);
    for (int i = 0; i < 3; i++) begin
      push(F_OK, 32'd0);
      push(F_OK, 32'h00FF_8000);
    end
    pulse_start();
    wait_end("retry_end", 400);
    idle(10);
    n41 = 0;
    foreach (cmd_log[i]) if (cmd_log[i] == C41) n41++;
    nvec++;
    if (n41 != 3 || cmd_log.size() != 8) begin
      nmis++;
      $display("FAIL retry_polls: cmd41 %0d total %0d, need 3 8",
               n41, cmd_log.size());
    end
    nvec++;
    if (err_code !== 3'd3 || ocr !== 32'h00FF8000) begin
      nmis++;
      $display("FAIL retry_code: err %0d ocr %h, need 3 00ff8000",
               err_code, ocr);
    end
  endtask

  task automatic test_err_codes();
    cmd_log.delete();
    push(F_OK, 32'd0);
    push(F_OK, 32'h0000_01AA);
    push(F_TO | F_END | F_CRC | F_IDX, 32'd0);
    pulse_start();
    wait_end("tmo_end", 200);
    nvec++;
    if (err_code !== 3'd4 || cmd_log.size() != 3) begin
      nmis++;
      $display("FAIL tmo_code: err %0d log %0d, need 4 3",
               err_code, cmd_log.size());
    end
    idle(3);
    cmd_log.delete();
    push(F_OK, 32'd0);
    push(F_OK, 32'h0000_01AA);
    push(F_OK, 32'd0);
    push(F_OK, 32'h80FF_8000);
    push(F_CRC, 32'd0);
    pulse_start();
    wait_end("crc_end", 300);
    nvec++;
    if (err_code !== 3'd2 || cmd_log.size() != 5) begin
      nmis++;
      $display("FAIL cmd2_crc: err %0d log %0d, need 2 5",
               err_code, cmd_log.size());
    end
    idle(3);
  endtask

  task automatic test_busy_hold();
    logic [38:0] e[6];
    int d0;
    int seen;
    e = '{C0, C8, C55, C41, C2, C3};
    cmd_log.delete();
    d0 = done_cnt;
    push(F_OK, 32'd0);
    push(F_OK, 32'h0000_01AA);
    push(F_OK, 32'd0);
    push(F_OK, 32'h80FF_8000);
    push(F_OK, 32'd0);
    push(F_OK, 32'h0001_0000);
    cmd_busy = 1'b1;
    pulse_start();
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (send_cmd_req) seen++;
    end
    nvec++;
    if (seen != 0 || cmd_log.size() != 0 || busy !== 1'b1) begin
      nmis++;
      $display("FAIL busy_hold: reqs %0d busy %b, need 0 1", seen, busy);
    end
    cmd_busy = 1'b0;
    wait_log("busy_release", 2);
    pulse_start();
    wait_end("busy_end", 400);
    nvec++;
    if (done_cnt - d0 != 1 || rca !== 16'h0001 || cmd_log.size() != 6) begin
      nmis++;
      $display("FAIL busy_done: dones %0d rca %h log %0d, need 1 0001 6",
               done_cnt - d0, rca, cmd_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        nvec++;
        if (cmd_log[i] !== e[i]) begin
          nmis++;
          $display("FAIL busy_cmd%0d: got %h, need %h", i, cmd_log[i], e[i]);
        end
      end
    end
    idle(3);
  endtask

  task automatic test_reset_mid();
    int d0;
    int f0;
    cmd_log.delete();
    d0 = done_cnt;
    f0 = fail_cnt;
    push(F_OK, 32'd0);
    pulse_start();
    nvec++;
    if (err_code !== 3'd0 || rca !== 16'd0) begin
      nmis++;
      $display("FAIL start_clear: err %0d rca %h, need 0 0000",
               err_code, rca);
    end
    wait_log("mid_wait", 2);
    idle(3);
    resetn = 1'b0;
    rq.delete();
    idle(1);
    nvec++;
    if ({busy, done, fail, send_cmd_req, resp_change, exp_r2,
         v1_card, high_cap} !== 8'h00 ||
        {err_code, rca, ocr, cmd_out, resp_addr} !== 91'd0) begin
      nmis++;
      $display("FAIL mid_reset: busy %b cmd %h err %0d rca %h ocr %h",
               busy, cmd_out, err_code, rca, ocr);
    end
    idle(1);
    resetn = 1'b1;
    idle(10);
    nvec++;
    if (done_cnt != d0 || fail_cnt != f0 || cmd_log.size() != 2 ||
        busy !== 1'b0) begin
      nmis++;
      $display("FAIL mid_quiet: dones %0d fails %0d log %0d busy %b",
               done_cnt - d0, fail_cnt - f0, cmd_log.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_happy();
    test_v1();
    test_echo();
    test_retry();
    test_err_codes();
    test_busy_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
